// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arb
// Brief    : Round-robin owner arbitration, beat sequencing and result tagging
//            for the shared multiplier bank. Optional MULT_ARB_OPGATE_EN
//            zeroes the operand bus outside ISSUE cycles.
// Revision : 1.0  initial release
// ============================================================================
module mult_share_arb #(
  parameter int NREQ  = 2,
  parameter int LANES = 36,
  parameter int W     = 36,
  parameter int LAT   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ-1:0][7:0]           req_beats,
  input  logic [NREQ-1:0][LANES*W-1:0]   req_dataa,
  input  logic [NREQ-1:0][LANES*W-1:0]   req_datab,
  output logic [NREQ-1:0]                gnt,
  output logic [7:0]                     count,
  output logic [LANES*W-1:0]             mult_dataa,
  output logic [LANES*W-1:0]             mult_datab,
  input  logic [LANES*W-1:0]             mult_result,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [LANES*W-1:0]             rsp_result,
  output logic [NREQ-1:0]                done,
  output logic                           busy
);

  localparam int             IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0]    c_nreq     = (IW+1)'(NREQ);
  localparam logic [LAT-1:0] c_pipe_top = LAT'(1) << (LAT-1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       r_ptr;
  logic [7:0]          r_beats_m1;
  logic [7:0]          r_count;
  logic [LAT-1:0]      r_pipe;

  logic                w_any;
  logic                w_issue;
  logic                w_last_beat;
  logic                w_drained;
  logic [2*NREQ-1:0]   w_req_dbl;
  logic [IW-1:0]       w_ofs;
  logic [IW:0]         w_sum;
  logic [IW-1:0]       w_win;
  logic [7:0]          w_beats_sel;
  logic [NREQ-1:0]     w_owner_oh;
  logic [LANES*W-1:0]  w_sel_a;
  logic [LANES*W-1:0]  w_sel_b;

  // Rotating the doubled request vector by ptr turns round-robin into a
  // fixed-priority search from bit 0; the offset is then added back to ptr.
  assign w_any     = |req;
  assign w_req_dbl = {req, req} >> r_ptr;

  always_comb begin
    w_ofs = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (w_req_dbl[i]) w_ofs = IW'(i);
    end
  end

  assign w_sum       = {1'b0, r_ptr} + {1'b0, w_ofs};
  assign w_win       = (w_sum >= c_nreq) ? IW'(w_sum - c_nreq) : w_sum[IW-1:0];
  assign w_beats_sel = req_beats[w_win];

  assign w_issue     = (r_state == c_issue);
  assign w_last_beat = (r_count == r_beats_m1);
  assign w_drained   = ((r_pipe & ~c_pipe_top) == '0);
  assign w_owner_oh  = NREQ'(1) << r_owner;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_idle;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (w_any)       w_next = c_issue;
      c_issue: if (w_last_beat) w_next = c_drain;
      c_drain: if (w_drained)   w_next = c_done;
      c_done:                   w_next = c_idle;
      default:                  w_next = c_idle;
    endcase
  end

  always_comb begin
    gnt       = '0;
    count     = '0;
    done      = '0;
    busy      = 1'b0;
    rsp_valid = '0;
    case (r_state)
      c_issue: begin
        gnt   = w_owner_oh;
        count = r_count;
        busy  = 1'b1;
      end
      c_drain: busy = 1'b1;
      c_done: begin
        done = w_owner_oh;
        busy = 1'b1;
      end
      default: ;
    endcase
    if (r_pipe[LAT-1]) rsp_valid = w_owner_oh;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= '0;
      r_ptr      <= '0;
      r_beats_m1 <= '0;
      r_count    <= '0;
      r_pipe     <= '0;
    end else begin
      r_pipe <= (r_pipe << 1) | LAT'(w_issue);
      case (r_state)
        c_idle: begin
          if (w_any) begin
            r_owner    <= w_win;
            r_beats_m1 <= (w_beats_sel == 8'd0) ? 8'd0 : w_beats_sel - 8'd1;
            r_count    <= 8'd0;
          end
        end
        c_issue: r_count <= w_last_beat ? 8'd0 : r_count + 8'd1;
        c_done:  r_ptr   <= (r_owner == IW'(NREQ-1)) ? '0 : r_owner + IW'(1);
        default: ;
      endcase
    end
  end

  assign w_sel_a = req_dataa[r_owner];
  assign w_sel_b = req_datab[r_owner];

`ifdef MULT_ARB_OPGATE_EN
  assign mult_dataa = w_issue ? w_sel_a : '0;
  assign mult_datab = w_issue ? w_sel_b : '0;
`else
  assign mult_dataa = rst ? w_sel_a : '0;
  assign mult_datab = rst ? w_sel_b : '0;
`endif

  assign rsp_result = mult_result;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arb
// Brief    : Directed scoreboard bench for mult_share_arb with a LAT-deep
//            multiplier bank model and per-cycle timing expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_share_arb;

  localparam int NREQ  = 2;
  localparam int LANES = 36;
  localparam int W     = 36;
  localparam int LAT   = 3;
  localparam int VW    = LANES*W;

  typedef logic [VW-1:0] vec_t;
  typedef struct { int r; vec_t res; } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0][7:0]     req_beats;
  logic [NREQ-1:0][VW-1:0]  req_dataa;
  logic [NREQ-1:0][VW-1:0]  req_datab;
  logic [NREQ-1:0]          gnt;
  logic [7:0]               count;
  vec_t                     mult_dataa;
  vec_t                     mult_datab;
  vec_t                     mult_result;
  logic [NREQ-1:0]          rsp_valid;
  vec_t                     rsp_result;
  logic [NREQ-1:0]          done;
  logic                     busy;

  mult_share_arb #(.NREQ(NREQ), .LANES(LANES), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_beats(req_beats),
    .req_dataa(req_dataa), .req_datab(req_datab), .gnt(gnt), .count(count),
    .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_result(mult_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   sr[8];
  int   st[8];
  int   sbt[8];
  int   ns;
  int   last_own;

  function automatic logic [W-1:0] opa(int r, int beat, int lane);
    logic [63:0] v;
    v = 64'(5 + 16*r + 3*beat + lane) + (64'(lane) << 24);
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] opb(int r, int beat, int lane);
    logic [63:0] v;
    v = 64'(7 + 8*r + 2*beat + 2*lane) + (64'(lane) << 20);
    return v[W-1:0];
  endfunction

  function automatic vec_t vec_a(int r, int beat);
    vec_t v;
    for (int l = 0; l < LANES; l++) v[l*W +: W] = opa(r, beat, l);
    return v;
  endfunction

  function automatic vec_t vec_b(int r, int beat);
    vec_t v;
    for (int l = 0; l < LANES; l++) v[l*W +: W] = opb(r, beat, l);
    return v;
  endfunction

  function automatic vec_t prod_vec(vec_t a, vec_t b);
    vec_t v;
    logic [2*W-1:0] p;
    for (int l = 0; l < LANES; l++) begin
      p = {W'(0), a[l*W +: W]} * {W'(0), b[l*W +: W]};
      v[l*W +: W] = p[W-1:0];
    end
    return v;
  endfunction

  function automatic int first_diff(vec_t a, vec_t b);
    for (int l = 0; l < LANES; l++) if (a[l*W +: W] !== b[l*W +: W]) return l;
    return 0;
  endfunction

  // Requesters answer the beat index combinationally; the bank is LAT deep.
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      req_dataa[r] = vec_a(r, int'(count));
      req_datab[r] = vec_b(r, int'(count));
    end
  end

  vec_t bank [LAT];
  always @(posedge clk) begin
    bank[0] <= prod_vec(mult_dataa, mult_datab);
    for (int k = 1; k < LAT; k++) bank[k] <= bank[k-1];
  end
  assign mult_result = bank[LAT-1];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_vec(string tag, vec_t obs, vec_t exp);
    int l;
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      l = first_diff(obs, exp);
      $error("FAIL %s: lane %0d observed %h expected %h (cycle %0d)",
             tag, l, obs[l*W +: W], exp[l*W +: W], cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid !== '0) begin
      chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_owner", 64'(rsp_valid), 64'(1 << e.r));
        chk_vec("rsp_result", rsp_result, e.res);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sched(int r, int t, int b, bit push);
    int bb;
    bb = (b == 0) ? 1 : b;
    sr[ns] = r; st[ns] = t; sbt[ns] = bb;
    ns++;
    if (push) for (int k = 0; k < bb; k++) sb.push_back('{r, prod_vec(vec_a(r, k), vec_b(r, k))});
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_gnt"},   64'(gnt), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_rsp"},   64'(rsp_valid), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk_vec({tag, "_dataa"}, mult_dataa, '0);
    chk_vec({tag, "_datab"}, mult_datab, '0);
  endtask

  // Expected outputs for relative cycles 1..ncyc derived from the burst schedule.
  task automatic run_window(int ncyc, int drop_at, logic [NREQ-1:0] req_after);
    logic [NREQ-1:0] g, rv, dn;
    logic bz;
    int   cnt, own;
    vec_t ea, eb;
    own = last_own;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (c == drop_at) req = req_after;
      g = '0; rv = '0; dn = '0; bz = 1'b0; cnt = 0; own = last_own;
      for (int k = 0; k < ns; k++) begin
        if (c >= st[k]+1 && c <= st[k]+sbt[k]) begin g[sr[k]] = 1'b1; cnt = c - st[k] - 1; end
        if (c >= st[k]+1+LAT && c <= st[k]+sbt[k]+LAT) rv[sr[k]] = 1'b1;
        if (c == st[k]+sbt[k]+LAT+1) dn[sr[k]] = 1'b1;
        if (c >= st[k]+1 && c <= st[k]+sbt[k]+LAT+1) bz = 1'b1;
        if (c >= st[k]+1) own = sr[k];
      end
      if (g != '0) begin
        ea = vec_a(own, cnt);
        eb = vec_b(own, cnt);
      end else begin
`ifdef MULT_ARB_OPGATE_EN
        ea = '0;
        eb = '0;
`else
        ea = vec_a(own, 0);
        eb = vec_b(own, 0);
`endif
      end
      chk("gnt",       64'(gnt), 64'(g));
      chk("count",     64'(count), 64'(cnt));
      chk("rsp_valid", 64'(rsp_valid), 64'(rv));
      chk("done",      64'(done), 64'(dn));
      chk("busy",      64'(busy), 64'(bz));
      chk_vec("mult_dataa", mult_dataa, ea);
      chk_vec("mult_datab", mult_datab, eb);
    end
    last_own = own;
  endtask

  initial begin
    rst = 1'b0; req = '0; req_beats = '0; ns = 0; last_own = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    // single 1-beat request from requester 0
    req_beats[0] = 8'd1; req = 2'b01; ns = 0;
    sched(0, 0, 1, 1'b1);
    run_window(6, 1, 2'b00);

    // burst of 4 from requester 1
    req_beats[1] = 8'd4; req = 2'b10; ns = 0;
    sched(1, 0, 4, 1'b1);
    run_window(9, 1, 2'b00);

    // contention straight out of reset, both held through the second IDLE
    rst = 1'b0;
    step();
    rst = 1'b1; last_own = 0;
    req_beats[0] = 8'd2; req_beats[1] = 8'd2; req = 2'b11; ns = 0;
    sched(0, 0, 2, 1'b1);
    sched(1, 7, 2, 1'b1);
    run_window(14, 8, 2'b00);

    // zero beats behaves as one
    req_beats[1] = 8'd0; req = 2'b10; ns = 0;
    sched(1, 0, 0, 1'b1);
    run_window(6, 1, 2'b00);

    // request dropped after the first grant cycle
    req_beats[0] = 8'd3; req = 2'b01; ns = 0;
    sched(0, 0, 3, 1'b1);
    run_window(8, 2, 2'b00);

    // reset during the second ISSUE cycle abandons the burst
    req_beats[1] = 8'd4; req = 2'b10; ns = 0;
    sched(1, 0, 4, 1'b0);
    run_window(2, 0, 2'b10);
    rst = 1'b0;
    #1;
    check_zero("midrst");
    last_own = 0;
    step();
    rst = 1'b1;
    req_beats[1] = 8'd1; req = 2'b10; ns = 0;
    sched(1, 0, 1, 1'b1);
    run_window(6, 1, 2'b00);

    repeat (5) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
